mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; all encodings SHALL be fixed as stated below.
REQ-002 clk  input  1  sole clock; all state changes SHALL occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode field [31:26], sampled in DECODE.
REQ-005 funct  input  6  instruction funct field [5:0], used in EXEC.
REQ-006 zero  input  1  ALU zero flag, used in BEQ/BNE.
REQ-007 alu_sel  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-008 alusrca  output  1  ALU A select: 0 PC, 1 register A.
REQ-009 alusrcb  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 pc_en, ir_write, mem_write, reg_write  output  1 each  write enables.
REQ-012 iord, reg_dst, mem_to_reg  output  1 each  mux selects (iord 1 = data address).
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 state  output  4  current state code, for debug.

Function
REQ-015 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12; codes 13-15 SHALL return to FETCH on the next edge.
REQ-016 Outputs SHALL be combinational decode of the state register (plus zero for pc_en); any output not listed for a state SHALL be 0.
REQ-017 FETCH: ir_write=1, pc_en=1, alusrcb=01, alu_sel=010; next DECODE.
REQ-018 DECODE: alusrcb=11, alu_sel=010; next by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP, 000101 -> BNE (macro only), any other -> FETCH with illegal=1 this cycle.
REQ-019 MEMADR: alusrca=1, alusrcb=10, alu_sel=010; next MEMRD if op=100011, else MEMWR.
REQ-020 MEMRD: iord=1; next MEMWB. MEMWB: mem_to_reg=1, reg_write=1; next FETCH.
REQ-021 MEMWR: iord=1, mem_write=1; next FETCH.
REQ-022 EXEC: alusrca=1, alusrcb=00; alu_sel from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010; next ALUWB.
REQ-023 ALUWB: reg_dst=1, reg_write=1; next FETCH.
REQ-024 BEQ: alusrca=1, alu_sel=110, pcsrc=01, pc_en=zero; next FETCH.
REQ-025 ADDIEX: alusrca=1, alusrcb=10, alu_sel=010; next ADDIWB. ADDIWB: reg_write=1; next FETCH.
REQ-026 JUMP: pcsrc=10, pc_en=1; next FETCH.
REQ-027 Cycles per instruction, FETCH to FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, illegal 2.
REQ-028 op and funct SHALL be sampled only in the states that use them; changes in other states SHALL have no effect.

Reset
REQ-029 rst_n low SHALL force state to FETCH immediately, without waiting for clk.
REQ-030 While rst_n is low, pc_en, ir_write, mem_write, reg_write and illegal SHALL be 0, and all other outputs SHALL take their FETCH values.
REQ-031 Reset mid-instruction SHALL abandon the instruction; the first rising edge after release SHALL execute FETCH.

Configuration
REQ-032 With macro MC_BNE_EN defined: op 000101 -> BNE; BNE drives alusrca=1, alu_sel=110, pcsrc=01, pc_en=~zero; next FETCH.
REQ-033 With MC_BNE_EN undefined: op 000101 SHALL be treated as illegal per REQ-018, and state code 12 SHALL be unreachable.

Verification
REQ-034 Reset release, op=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-035 op=000000, funct=101010 -> alu_sel=111 in EXEC; reg_dst=1 and reg_write=1 in ALUWB; 4 cycles total.
REQ-036 op=000100 with zero=1, then again with zero=0 -> pc_en=1 then 0 in BEQ, pcsrc=01 both times.
REQ-037 op=111111 -> illegal pulses for exactly one cycle in DECODE, then FETCH; no write enable asserted.
REQ-038 rst_n asserted asynchronously in MEMWR -> state=0 and mem_write=0 before the next clk edge.
REQ-039 op=000101, zero=0: with MC_BNE_EN -> pc_en=1 in state 12; without it -> illegal=1, return to FETCH.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bus between the multicycle controller and its datapath.
// Carries the instruction fields and zero flag into the controller and the
// mux selects, ALU operation, write enables and debug state code out of it.
//   master : controller side (drives controls, reads op/funct/zero)
//   slave  : datapath side   (drives op/funct/zero, reads controls)
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_sel;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pc_en;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output alu_sel, alusrca, alusrcb, pcsrc, pc_en, ir_write, mem_write,
           reg_write, iord, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  alu_sel, alusrca, alusrcb, pcsrc, pc_en, ir_write, mem_write,
           reg_write, iord, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-style main controller (lw, sw, R-type, beq, addi, j, bne).
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset, forces FETCH immediately
//   bus   - mc_control_if.master: op/funct/zero in; ALU/mux selects,
//           write enables, illegal pulse and 4-bit state code out
// Controls are a combinational decode of the state register (plus zero for
// pc_en and op for the illegal pulse in DECODE).
// Optional feature: define MC_BNE_EN to decode op 000101 as BNE; otherwise
// that opcode is illegal and state code 12 is never entered.
module mc_control (
  input  logic           clk,
  input  logic           rst_n,
  mc_control_if.master   bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BEQ    = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_BNE    = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q;
  state_e state_d;

  logic [2:0] alu_sel_c;
  logic       alusrca_c;
  logic [1:0] alusrcb_c;
  logic [1:0] pcsrc_c;
  logic       pc_en_c;
  logic       ir_write_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic       iord_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       illegal_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = ST_FETCH;
    alu_sel_c    = 3'b000;
    alusrca_c    = 1'b0;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    pc_en_c      = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    iord_c       = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_write_c = 1'b1;
        pc_en_c    = 1'b1;
        alusrcb_c  = 2'b01;
        alu_sel_c  = ALU_ADD;
        state_d    = ST_DECODE;
      end

      ST_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded
        alusrcb_c = 2'b11;
        alu_sel_c = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BEQ;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = ST_BNE;
`endif
          default: begin
            state_d   = ST_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end

      ST_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        alu_sel_c = ALU_ADD;
        state_d   = (bus.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        iord_c  = 1'b1;
        state_d = ST_MEMWB;
      end

      ST_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_EXEC: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b00;
        case (bus.funct)
          FN_ADD:  alu_sel_c = ALU_ADD;
          FN_SUB:  alu_sel_c = ALU_SUB;
          FN_AND:  alu_sel_c = ALU_AND;
          FN_OR:   alu_sel_c = ALU_OR;
          FN_SLT:  alu_sel_c = ALU_SLT;
          default: alu_sel_c = ALU_ADD;
        endcase
        state_d = ST_ALUWB;
      end

      ST_ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_BEQ: begin
        alusrca_c = 1'b1;
        alu_sel_c = ALU_SUB;
        pcsrc_c   = 2'b01;
        pc_en_c   = bus.zero;
        state_d   = ST_FETCH;
      end

      ST_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        alu_sel_c = ALU_ADD;
        state_d   = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end

      ST_JUMP: begin
        pcsrc_c = 2'b10;
        pc_en_c = 1'b1;
        state_d = ST_FETCH;
      end

`ifdef MC_BNE_EN
      ST_BNE: begin
        alusrca_c = 1'b1;
        alu_sel_c = ALU_SUB;
        pcsrc_c   = 2'b01;
        pc_en_c   = ~bus.zero;
        state_d   = ST_FETCH;
      end
`endif

      // Unused codes (13-15, and 12 without BNE) recover to FETCH
      default: state_d = ST_FETCH;
    endcase
  end

  // Drive the bus; write enables and illegal are held low during reset
  always_comb begin
    bus.alu_sel    = alu_sel_c;
    bus.alusrca    = alusrca_c;
    bus.alusrcb    = alusrcb_c;
    bus.pcsrc      = pcsrc_c;
    bus.iord       = iord_c;
    bus.reg_dst    = reg_dst_c;
    bus.mem_to_reg = mem_to_reg_c;
    bus.pc_en      = pc_en_c     & rst_n;
    bus.ir_write   = ir_write_c  & rst_n;
    bus.mem_write  = mem_write_c & rst_n;
    bus.reg_write  = reg_write_c & rst_n;
    bus.illegal    = illegal_c   & rst_n;
    bus.state      = 4'(state_q);
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through the
// FSM and checks state codes and controls against hand-derived values.
module tb_mc_control;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sum of all write enables, used to assert none are active
  function automatic logic [31:0] wr_any();
    return 32'(bus.pc_en | bus.ir_write | bus.mem_write | bus.reg_write);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    // Reset: FETCH selects with write enables forced low
    #12;
    chk("rst_state",    32'(bus.state),    32'd0);
    chk("rst_pc_en",    32'(bus.pc_en),    32'd0);
    chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("rst_alusrcb",  32'(bus.alusrcb),  32'd1);
    chk("rst_alu_sel",  32'(bus.alu_sel),  32'd2);
    chk("rst_illegal",  32'(bus.illegal),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // lw: 0,1,2,3,4,0
    chk("lw_fetch_irw",  32'(bus.ir_write), 32'd1);
    chk("lw_fetch_pce",  32'(bus.pc_en),    32'd1);
    step();
    chk("lw_s1",         32'(bus.state),    32'd1);
    chk("lw_dec_srcb",   32'(bus.alusrcb),  32'd3);
    chk("lw_dec_wr",     wr_any(),          32'd0);
    step();
    chk("lw_s2",         32'(bus.state),    32'd2);
    chk("lw_adr_srca",   32'(bus.alusrca),  32'd1);
    chk("lw_adr_srcb",   32'(bus.alusrcb),  32'd2);
    step();
    chk("lw_s3",         32'(bus.state),    32'd3);
    chk("lw_rd_iord",    32'(bus.iord),     32'd1);
    chk("lw_rd_regw",    32'(bus.reg_write),32'd0);
    bus.op = 6'b111111;  // ignored outside DECODE/MEMADR
    step();
    chk("lw_s4",         32'(bus.state),    32'd4);
    chk("lw_wb_regw",    32'(bus.reg_write),32'd1);
    chk("lw_wb_m2r",     32'(bus.mem_to_reg),32'd1);
    step();
    chk("lw_s0",         32'(bus.state),    32'd0);
    chk("lw_f_m2r",      32'(bus.mem_to_reg),32'd0);

    // R-type slt: 4 cycles
    bus.op = 6'b000000; bus.funct = 6'b101010;
    step();
    chk("rt_s1",         32'(bus.state),    32'd1);
    step();
    chk("rt_s6",         32'(bus.state),    32'd6);
    chk("rt_slt",        32'(bus.alu_sel),  32'd7);
    chk("rt_srca",       32'(bus.alusrca),  32'd1);
    chk("rt_srcb",       32'(bus.alusrcb),  32'd0);
    step();
    chk("rt_s7",         32'(bus.state),    32'd7);
    chk("rt_regdst",     32'(bus.reg_dst),  32'd1);
    chk("rt_regw",       32'(bus.reg_write),32'd1);
    step();
    chk("rt_s0",         32'(bus.state),    32'd0);

    // R-type sub and unknown funct
    bus.funct = 6'b100010;
    step(); step();
    chk("rt_sub",        32'(bus.alu_sel),  32'd6);
    step(); step();
    bus.funct = 6'b111111;
    step(); step();
    chk("rt_dflt",       32'(bus.alu_sel),  32'd2);
    step(); step();

    // beq taken then not taken
    bus.op = 6'b000100; bus.zero = 1'b1;
    step(); step();
    chk("beq1_s8",       32'(bus.state),    32'd8);
    chk("beq1_pce",      32'(bus.pc_en),    32'd1);
    chk("beq1_pcsrc",    32'(bus.pcsrc),    32'd1);
    chk("beq1_alu",      32'(bus.alu_sel),  32'd6);
    step();
    chk("beq1_s0",       32'(bus.state),    32'd0);
    bus.zero = 1'b0;
    step(); step();
    chk("beq0_pce",      32'(bus.pc_en),    32'd0);
    chk("beq0_pcsrc",    32'(bus.pcsrc),    32'd1);
    step();

    // illegal opcode: one-cycle pulse then FETCH
    bus.op = 6'b111111;
    chk("ill_f_pulse",   32'(bus.illegal),  32'd0);
    step();
    chk("ill_pulse",     32'(bus.illegal),  32'd1);
    chk("ill_nowr",      wr_any(),          32'd0);
    step();
    chk("ill_s0",        32'(bus.state),    32'd0);
    chk("ill_clear",     32'(bus.illegal),  32'd0);

    // addi
    bus.op = 6'b001000;
    step(); step();
    chk("addi_s9",       32'(bus.state),    32'd9);
    chk("addi_srcb",     32'(bus.alusrcb),  32'd2);
    step();
    chk("addi_s10",      32'(bus.state),    32'd10);
    chk("addi_regw",     32'(bus.reg_write),32'd1);
    chk("addi_regdst",   32'(bus.reg_dst),  32'd0);
    step();

    // jump
    bus.op = 6'b000010;
    step(); step();
    chk("j_s11",         32'(bus.state),    32'd11);
    chk("j_pcsrc",       32'(bus.pcsrc),    32'd2);
    chk("j_pce",         32'(bus.pc_en),    32'd1);
    step();
    chk("j_s0",          32'(bus.state),    32'd0);

    // bne with zero=0
    bus.op = 6'b000101; bus.zero = 1'b0;
    step();
`ifdef MC_BNE_EN
    chk("bne_noill",     32'(bus.illegal),  32'd0);
    step();
    chk("bne_s12",       32'(bus.state),    32'd12);
    chk("bne_pce",       32'(bus.pc_en),    32'd1);
    chk("bne_pcsrc",     32'(bus.pcsrc),    32'd1);
    step();
`else
    chk("bne_ill",       32'(bus.illegal),  32'd1);
    step();
`endif
    chk("bne_s0",        32'(bus.state),    32'd0);

    // sw, then async reset while in MEMWR
    bus.op = 6'b101011;
    step(); step();
    chk("sw_s2",         32'(bus.state),    32'd2);
    step();
    chk("sw_s5",         32'(bus.state),    32'd5);
    chk("sw_memw",       32'(bus.mem_write),32'd1);
    chk("sw_iord",       32'(bus.iord),     32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",    32'(bus.state),    32'd0);
    chk("arst_memw",     32'(bus.mem_write),32'd0);
    chk("arst_iord",     32'(bus.iord),     32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_state",     32'(bus.state),    32'd0);
    chk("rel_irw",       32'(bus.ir_write), 32'd1);
    step();
    chk("rel_s1",        32'(bus.state),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
